// File: rtl/mem_access_stage.sv
// Stage-3 memory-access controller: passes non-memory ops through, runs loads/stores over a
// req/ack handshake while stalling upstream. Optional access timeout via `define MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_in,
    input  logic [15:0] store_data_in,
    input  logic [3:0]  rd_addr_in,
    input  logic [1:0]  mem_signals_in,
    input  logic [2:0]  wb_signals_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [15:0] alu_out,
    output logic [15:0] data_out,
    output logic [3:0]  rd_addr_out,
    output logic [2:0]  wb_signals_out,
    output logic        dmem_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0]  rd_q, rd_d;
    logic [2:0]  wb_q, wb_d;
    logic        we_q, we_d;
    logic        mem_op;

    assign mem_op = |mem_signals_in;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       expired;

    assign expired  = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign dmem_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^8'(TIMEOUT_CYCLES);
    assign dmem_err       = 1'b0;
`endif

    // Request side is only driven in BUSY so nothing stale leaks onto the memory bus.
    assign dmem_req   = (state_q == BUSY);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = dmem_req ? addr_q  : 16'h0000;
    assign dmem_wdata = dmem_req ? wdata_q : 16'h0000;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        rd_d           = rd_q;
        wb_d           = wb_q;
        we_d           = we_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_d          = err_q;
`endif
        stall          = 1'b0;
        alu_out        = 16'h0000;
        data_out       = 16'h0000;
        rd_addr_out    = 4'h0;
        wb_signals_out = 3'b000;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall   = 1'b1;
                    addr_d  = alu_in;
                    wdata_d = store_data_in;
                    rd_d    = rd_addr_in;
                    wb_d    = wb_signals_in;
                    we_d    = mem_signals_in[1];
                    rdata_d = 16'h0000;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    state_d = BUSY;
                end else begin
                    alu_out        = alu_in;
                    rd_addr_out    = rd_addr_in;
                    wb_signals_out = wb_signals_in;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    rdata_d = we_q ? 16'h0000 : dmem_rdata;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // A timed-out op completes with its writeback suppressed.
                else if (expired) begin
                    rdata_d = 16'h0000;
                    wb_d    = 3'b000;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                alu_out        = addr_q;
                data_out       = rdata_q;
                rd_addr_out    = rd_q;
                wb_signals_out = wb_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            rd_q    <= 4'h0;
            wb_q    <= 3'b000;
            we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            we_q    <= we_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB words are queued at issue and
// compared in the cycle the stage releases stall.
module tb_mem_access_stage;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] data;
        logic [3:0]  rd;
        logic [2:0]  wb;
    } wb_word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_in, store_data_in, dmem_rdata;
    logic [3:0]  rd_addr_in;
    logic [1:0]  mem_signals_in;
    logic [2:0]  wb_signals_in;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, dmem_err;
    logic [15:0] dmem_addr, dmem_wdata, alu_out, data_out;
    logic [3:0]  rd_addr_out;
    logic [2:0]  wb_signals_out;

    int n_checks = 0;
    int n_errors = 0;
    wb_word_t exp_q[$];

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_in        (alu_in),
        .store_data_in (store_data_in),
        .rd_addr_in    (rd_addr_in),
        .mem_signals_in(mem_signals_in),
        .wb_signals_in (wb_signals_in),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .alu_out       (alu_out),
        .data_out      (data_out),
        .rd_addr_out   (rd_addr_out),
        .wb_signals_out(wb_signals_out),
        .dmem_err      (dmem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] sd, input logic [3:0] rd,
                         input logic [1:0] mem, input logic [2:0] wb);
        alu_in         = a;
        store_data_in  = sd;
        rd_addr_in     = rd;
        mem_signals_in = mem;
        wb_signals_in  = wb;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_bubble"}, {alu_out, data_out, rd_addr_out, wb_signals_out}, '0);
    endtask

    task automatic pop_check(input string tag);
        wb_word_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_alu_out"},  alu_out,        e.alu);
            check({tag, "_data_out"}, data_out,       e.data);
            check({tag, "_rd_out"},   rd_addr_out,    e.rd);
            check({tag, "_wb_out"},   wb_signals_out, e.wb);
        end
    endtask

    task automatic run_nonmem(input string tag, input logic [15:0] a, input logic [15:0] sd,
                              input logic [3:0] rd, input logic [2:0] wb, input logic ack);
        cycle();
        drive(a, sd, rd, 2'b00, wb);
        dmem_ack = ack;
        exp_q.push_back('{alu: a, data: 16'h0000, rd: rd, wb: wb});
        #1;
        check({tag, "_stall"}, stall, 1'b0);
        check({tag, "_req"}, dmem_req, 1'b0);
        pop_check(tag);
    endtask

    // ack_at: BUSY cycle index (0 = first) carrying the ack; negative means never ack.
    task automatic run_mem_op(input string tag, input logic [15:0] a, input logic [15:0] sd,
                              input logic [3:0] rd, input logic [1:0] mem, input logic [2:0] wb,
                              input int ack_at, input logic [15:0] rdata, input int exp_stalls);
        int       stalls;
        bit       done;
        wb_word_t e;
        cycle();
        drive(a, sd, rd, mem, wb);
        dmem_ack = 1'b0;
        e.alu  = a;
        e.data = (mem[1] || ack_at < 0) ? 16'h0000 : rdata;
        e.rd   = rd;
        e.wb   = (ack_at < 0) ? 3'b000 : wb;
        exp_q.push_back(e);
        #1;
        check({tag, "_issue_stall"}, stall, 1'b1);
        check({tag, "_issue_req"}, dmem_req, 1'b0);
        check_bubble({tag, "_issue"});
        stalls = 1;
        done   = 1'b0;
        for (int k = 0; k < 64; k++) begin
            cycle();
            dmem_ack = 1'b0;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            check({tag, "_busy_req"}, dmem_req, 1'b1);
            check({tag, "_busy_addr"}, dmem_addr, a);
            check({tag, "_busy_we"}, dmem_we, mem[1]);
            if (mem[1]) check({tag, "_busy_wdata"}, dmem_wdata, sd);
            check_bubble({tag, "_busy"});
            dmem_ack   = (k == ack_at);
            dmem_rdata = rdata;
            // Upstream is frozen but scramble the operands to prove DONE ignores them.
            if (k == ack_at) begin
                alu_in        = ~a;
                rd_addr_in    = ~rd;
                wb_signals_in = ~wb;
            end
        end
        if (!done) check({tag, "_wait_bound"}, stalls, exp_stalls);
        check({tag, "_stall_cycles"}, stalls, exp_stalls);
        check({tag, "_done_req"}, dmem_req, 1'b0);
        pop_check({tag, "_done"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0000;
        drive(16'h0000, 16'h0000, 4'h0, 2'b00, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {dmem_req, dmem_we, stall, dmem_err}, 4'b0000);
        check("reset_bus", {dmem_addr, dmem_wdata}, 32'h0);
        check_bubble("reset");
        rst = 1'b0;

        run_nonmem("pass1", 16'h1234, 16'h0000, 4'h5, 3'b101, 1'b0);
        run_nonmem("pass2", 16'hFFFF, 16'hDEAD, 4'hF, 3'b010, 1'b0);

        run_mem_op("load",  16'h0040, 16'h0000, 4'h3, 2'b01, 3'b011, 3, 16'hBEEF, 5);
        run_mem_op("store", 16'h0010, 16'hA5A5, 4'h7, 2'b10, 3'b100, 0, 16'h1234, 2);
        cycle();
        drive(16'h0000, 16'h0000, 4'h0, 2'b00, 3'b000);
        #1;
        check("post_store_we", dmem_we, 1'b0);
        run_mem_op("both",  16'h0022, 16'h5A5A, 4'h1, 2'b11, 3'b111, 1, 16'hFFFF, 3);
        run_mem_op("b2b",   16'h8002, 16'h0000, 4'h9, 2'b01, 3'b001, 0, 16'h7E57, 2);

        run_nonmem("spur_ack", 16'h00AA, 16'h0000, 4'h2, 3'b110, 1'b1);
        run_nonmem("spur_after", 16'h0055, 16'h0000, 4'h4, 3'b011, 1'b0);

        // Reset in the middle of an outstanding access.
        cycle();
        drive(16'h0100, 16'h0000, 4'h6, 2'b01, 3'b001);
        cycle();
        check("rstmid_req_before", dmem_req, 1'b1);
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 4'h0, 2'b00, 3'b000);
        #1;
        check("rstmid_ctrl", {dmem_req, dmem_we, stall}, 3'b000);
        check("rstmid_addr", dmem_addr, 16'h0000);
        check_bubble("rstmid");
        cycle();
        rst = 1'b0;
        run_nonmem("rstmid_after", 16'h4321, 16'h0000, 4'hA, 3'b100, 1'b0);
        check("rstmid_req_after", dmem_req, 1'b0);

`ifdef MEM_TIMEOUT_EN
        run_mem_op("ack_at_expiry", 16'h0200, 16'h0000, 4'hB, 2'b01, 3'b101, 3, 16'hC0DE, 5);
        check("err_after_late_ack", dmem_err, 1'b0);
        run_mem_op("timeout", 16'h0300, 16'h0000, 4'hC, 2'b01, 3'b111, -1, 16'h0000, 5);
        check("err_after_timeout", dmem_err, 1'b1);
        run_mem_op("after_to", 16'h0400, 16'h1111, 4'hD, 2'b10, 3'b010, 0, 16'h0000, 2);
        check("err_sticky", dmem_err, 1'b1);
`else
        check("err_tied_low", dmem_err, 1'b0);
`endif

        cycle();
        drive(16'h0000, 16'h0000, 4'h0, 2'b00, 3'b000);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
